instr_fetch_sequencer: RTL and testbench

- Fetch controller for the 16-bit single-cycle CPU's byte-wide instruction memory (256 bytes, big-endian 2-byte instructions: high byte at PC, low byte at PC+1).
- Owns the PC and issues two byte reads per instruction over a 1-cycle-latency synchronous read port.
- Assembles each 16-bit instruction and hands it to decode over a valid/ready handshake.
- Accepts branch/jump redirects and halt requests from the datapath.

---
 rtl/instr_fetch_sequencer.sv | 117 +++++++++++
 tb/tb_instr_fetch_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads two bytes per
// instruction and presents the assembled 16-bit word to decode.
module instr_fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_HI,
        S_LO,
        S_CAP,
        S_VALID
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hi_reg;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_HI;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a redirect always restarts at the high-byte read
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = S_HI;
        end else begin
            unique case (state)
                S_HI:    if (!halt_req) state_nxt = S_LO;
                S_LO:    state_nxt = S_CAP;
                S_CAP:   state_nxt = S_VALID;
                S_VALID: if (instr_ready) state_nxt = S_HI;
                default: state_nxt = S_HI;
            endcase
        end
    end

    // Memory strobe/address decoded from state, forced idle during reset
    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        if (!reset) begin
            unique case (state)
                S_HI: begin
                    mem_en   = ~halt_req;
                    mem_addr = pc;
                end
                S_LO: begin
                    mem_en   = 1'b1;
                    mem_addr = pc + 1'b1;
                end
                default: begin
                    mem_en   = 1'b0;
                    mem_addr = '0;
                end
            endcase
        end
    end

    // Busy whenever a fetch is in flight or an instruction waits on decode
    always_comb begin
        busy = (state == S_LO) | (state == S_CAP) | instr_valid;
    end

    // PC, byte capture and instruction holding registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            hi_reg      <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= {redirect_pc[ADDR_W-1:1], 1'b0};
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                S_LO: begin
                    hi_reg <= mem_rdata;
                end
                S_CAP: begin
                    instr       <= {hi_reg, mem_rdata};
                    instr_pc    <= pc;
                    pc          <= pc + ADDR_W'(2);
                    instr_valid <= 1'b1;
                end
                S_VALID: begin
                    if (instr_ready) instr_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with a 256-byte
// synchronous-read instruction memory model.
module tb_instr_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halt_req;
    logic [7:0]  pc;
    logic        busy;

    logic [7:0]  mem [256];

    int vectors;
    int miscompares;

    instr_fetch_sequencer #(
        .ADDR_W  (8),
        .RESET_PC(8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .pc            (pc),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle-latency synchronous read port
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        mem_rdata      = 8'h00;
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        halt_req       = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h31;
        mem[8'h01] = 8'h12;
        mem[8'h02] = 8'h34;
        mem[8'h03] = 8'h13;
        mem[8'h04] = 8'h77;
        mem[8'h05] = 8'h88;
        mem[8'h14] = 8'h36;
        mem[8'h15] = 8'h48;
        mem[8'hFE] = 8'hAB;
        mem[8'hFF] = 8'hCD;

        // Reset state
        repeat (2) step();
        chk("rst_pc",     16'(pc),          16'h0000);
        chk("rst_valid",  16'(instr_valid), 16'h0000);
        chk("rst_mem_en", 16'(mem_en),      16'h0000);
        chk("rst_addr",   16'(mem_addr),    16'h0000);
        chk("rst_instr",  instr,            16'h0000);
        chk("rst_busy",   16'(busy),        16'h0000);

        // Basic fetch with backpressure on the first instruction
        reset = 1'b0;
        #1;
        chk("f0_en",   16'(mem_en),   16'h0001);
        chk("f0_addr", 16'(mem_addr), 16'h0000);
        step();
        chk("f1_en",   16'(mem_en),   16'h0001);
        chk("f1_addr", 16'(mem_addr), 16'h0001);
        chk("f1_busy", 16'(busy),     16'h0001);
        step();
        chk("f2_en",    16'(mem_en),      16'h0000);
        chk("f2_valid", 16'(instr_valid), 16'h0000);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 16'(instr_valid), 16'h0001);
            chk("bp_instr", instr,            16'h3112);
            chk("bp_ipc",   16'(instr_pc),    16'h0000);
            chk("bp_en",    16'(mem_en),      16'h0000);
            chk("bp_pc",    16'(pc),          16'h0002);
            if (i < 4) step();
        end
        instr_ready = 1'b1;
        step();
        chk("i1_valid", 16'(instr_valid), 16'h0000);
        chk("i1_en",    16'(mem_en),      16'h0001);
        chk("i1_addr",  16'(mem_addr),    16'h0002);
        step();
        chk("i1_lo",    16'(mem_addr),    16'h0003);
        step();
        step();
        chk("i1_v",     16'(instr_valid), 16'h0001);
        chk("i1_instr", instr,            16'h3413);
        chk("i1_ipc",   16'(instr_pc),    16'h0002);
        chk("i1_pc",    16'(pc),          16'h0004);
        step();
        chk("i2_valid", 16'(instr_valid), 16'h0000);
        chk("i2_addr",  16'(mem_addr),    16'h0004);

        // Redirect while in S_LO discards the partial fetch
        step();
        chk("rd_lo_addr", 16'(mem_addr), 16'h0005);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h15;
        step();
        redirect_valid = 1'b0;
        chk("rd_pc",    16'(pc),          16'h0014);
        chk("rd_valid", 16'(instr_valid), 16'h0000);
        chk("rd_en",    16'(mem_en),      16'h0001);
        chk("rd_addr",  16'(mem_addr),    16'h0014);
        step();
        chk("rd_v1",    16'(instr_valid), 16'h0000);
        chk("rd_addr1", 16'(mem_addr),    16'h0015);
        step();
        chk("rd_v2",    16'(instr_valid), 16'h0000);
        step();
        chk("rd_v3",    16'(instr_valid), 16'h0001);
        chk("rd_instr", instr,            16'h3648);
        chk("rd_ipc",   16'(instr_pc),    16'h0014);
        chk("rd_pcn",   16'(pc),          16'h0016);

        // Redirect and accept together, target at the wrap point
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        step();
        redirect_valid = 1'b0;
        chk("ra_valid", 16'(instr_valid), 16'h0000);
        chk("ra_pc",    16'(pc),          16'h00FE);
        chk("ra_addr",  16'(mem_addr),    16'h00FE);
        step();
        chk("wr_lo",    16'(mem_addr),    16'h00FF);
        step();
        chk("wr_v0",    16'(instr_valid), 16'h0000);
        step();
        chk("wr_valid", 16'(instr_valid), 16'h0001);
        chk("wr_instr", instr,            16'hABCD);
        chk("wr_ipc",   16'(instr_pc),    16'h00FE);
        chk("wr_pc",    16'(pc),          16'h0000);

        // Halt in S_HI, with a redirect landing during the halt
        halt_req = 1'b1;
        step();
        chk("h0_en",   16'(mem_en),      16'h0000);
        chk("h0_pc",   16'(pc),          16'h0000);
        chk("h0_busy", 16'(busy),        16'h0000);
        chk("h0_v",    16'(instr_valid), 16'h0000);
        step();
        chk("h1_en", 16'(mem_en), 16'h0000);
        chk("h1_pc", 16'(pc),     16'h0000);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h03;
        step();
        redirect_valid = 1'b0;
        chk("h2_en", 16'(mem_en), 16'h0000);
        chk("h2_pc", 16'(pc),     16'h0002);
        step();
        chk("h3_en", 16'(mem_en), 16'h0000);
        chk("h3_pc", 16'(pc),     16'h0002);
        halt_req = 1'b0;
        #1;
        chk("hr_en",   16'(mem_en),   16'h0001);
        chk("hr_addr", 16'(mem_addr), 16'h0002);
        step();
        chk("hr_lo", 16'(mem_addr), 16'h0003);
        step();
        chk("hr_cap_en", 16'(mem_en), 16'h0000);

        // Asynchronous reset while in S_CAP
        reset = 1'b1;
        #1;
        chk("ar_valid", 16'(instr_valid), 16'h0000);
        chk("ar_pc",    16'(pc),          16'h0000);
        chk("ar_instr", instr,            16'h0000);
        chk("ar_ipc",   16'(instr_pc),    16'h0000);
        chk("ar_en",    16'(mem_en),      16'h0000);
        chk("ar_busy",  16'(busy),        16'h0000);
        step();
        chk("ar_hold_v", 16'(instr_valid), 16'h0000);
        reset = 1'b0;
        #1;
        chk("rs_en",   16'(mem_en),   16'h0001);
        chk("rs_addr", 16'(mem_addr), 16'h0000);
        step();
        chk("rs_lo", 16'(mem_addr), 16'h0001);
        step();
        step();
        chk("rs_valid", 16'(instr_valid), 16'h0001);
        chk("rs_instr", instr,            16'h3112);
        chk("rs_ipc",   16'(instr_pc),    16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
